// File: rtl/rom_copy_engine.sv
// Boot-time block copier: streams words from one port of the 512x32 ROM
// into a destination memory over a valid/ready write interface.
module rom_copy_engine #(
  parameter int ROM_ADDR_BITS = 9,
  parameter int RAM_ADDR_BITS = 27,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ROM_ADDR_BITS-1:0] src_addr,
  input  logic [RAM_ADDR_BITS-1:0] dst_addr,
  input  logic [ROM_ADDR_BITS:0]   length,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_q,
  output logic                     ram_wr_valid,
  input  logic                     ram_wr_ready,
  output logic [RAM_ADDR_BITS-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0]    ram_wr_data,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  localparam logic [ROM_ADDR_BITS:0] LAST_WORD = (ROM_ADDR_BITS+1)'(1);

  state_t                   state;
  state_t                   state_next;
  logic [ROM_ADDR_BITS-1:0] src_ptr;
  logic [RAM_ADDR_BITS-1:0] dst_ptr;
  logic [ROM_ADDR_BITS:0]   remaining;
  logic                     xfer;

  assign xfer = (state == WRITE) && ram_wr_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // READ presents the address, WAIT absorbs the ROM's registered read latency.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (length == '0) ? DONE : READ;
      READ:    state_next = WAIT;
      WAIT:    state_next = WRITE;
      WRITE:   if (ram_wr_ready) state_next = (remaining == LAST_WORD) ? DONE : READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr     <= '0;
      dst_ptr     <= '0;
      remaining   <= '0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        src_ptr   <= src_addr;
        dst_ptr   <= dst_addr;
        remaining <= length;
      end
      if (state == WAIT) begin
        ram_wr_data <= rom_q;
        ram_wr_addr <= dst_ptr;
      end
      // Both pointers wrap naturally at their own widths.
      if (xfer) begin
        src_ptr   <= src_ptr + ROM_ADDR_BITS'(1);
        dst_ptr   <= dst_ptr + RAM_ADDR_BITS'(1);
        remaining <= remaining - LAST_WORD;
      end
    end
  end

  assign rom_addr     = src_ptr;
  assign ram_wr_valid = (state == WRITE);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_rom_copy_engine.sv
// Self-checking bench for rom_copy_engine: table-driven block copies, hand
// sequences for reset/start corner cases, and randomized copies vs a model.
module tb_rom_copy_engine;

  typedef struct {
    logic [8:0]  src;
    logic [26:0] dst;
    logic [9:0]  len;
    int          stallWord;
    int          stallCycles;
    int          expWrites;
    int          expDoneCycle;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  src_addr;
  logic [26:0] dst_addr;
  logic [9:0]  length;
  logic [8:0]  rom_addr;
  logic [31:0] rom_q;
  logic        ram_wr_valid;
  logic        ram_wr_ready;
  logic [26:0] ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic        busy;
  logic        done;

  logic [31:0] rom_mem [512];
  logic [26:0] obsAddr [$];
  logic [31:0] obsData [$];
  vec_t        vecs [7];
  int          checks = 0;
  int          errors = 0;

  rom_copy_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .ram_wr_valid(ram_wr_valid), .ram_wr_ready(ram_wr_ready),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural ROM with one-cycle registered read.
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Record the handshake that will complete on the coming edge, then advance.
  task automatic stepCycle();
    if (ram_wr_valid === 1'b1 && ram_wr_ready === 1'b1) begin
      obsAddr.push_back(ram_wr_addr);
      obsData.push_back(ram_wr_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkBlock(input string tag, input logic [8:0] src, input logic [26:0] dst, input logic [9:0] len);
    logic [26:0] ea;
    int          idx;
    checkOutput({tag, "_count"}, obsAddr.size(), len);
    for (int k = 0; k < obsAddr.size() && k < int'(len); k++) begin
      ea  = dst + 27'(k);
      idx = (int'(src) + k) % 512;
      checkOutput({tag, "_addr"}, obsAddr[k], ea);
      checkOutput({tag, "_data"}, obsData[k], rom_mem[idx]);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] src, input logic [26:0] dst, input logic [9:0] len,
                               input int stallWord, input int stallCycles, input bit randomReady,
                               input bit startDuringWait, output int doneCycle);
    int          edges;
    int          stallLeft;
    bit          seenDone;
    bit          prevStall;
    logic [26:0] heldAddr;
    logic [31:0] heldData;
    obsAddr.delete();
    obsData.delete();
    src_addr     = src;
    dst_addr     = dst;
    length       = len;
    start        = 1'b1;
    ram_wr_ready = 1'b1;
    stepCycle();
    start     = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    edges     = 0;
    stallLeft = stallCycles;
    seenDone  = 1'b0;
    prevStall = 1'b0;
    doneCycle = -1;
    heldAddr  = '0;
    heldData  = '0;
    while (!seenDone && edges < 4000) begin
      if (prevStall) begin
        checkOutput("stall_valid", ram_wr_valid, 1);
        checkOutput("stall_addr", ram_wr_addr, heldAddr);
        checkOutput("stall_data", ram_wr_data, heldData);
      end
      if (done === 1'b1) begin
        seenDone  = 1'b1;
        doneCycle = edges;
      end else begin
        if (randomReady)
          ram_wr_ready = ($urandom_range(0, 3) != 0);
        else if (ram_wr_valid === 1'b1 && obsAddr.size() == stallWord && stallLeft > 0) begin
          ram_wr_ready = 1'b0;
          stallLeft--;
        end else
          ram_wr_ready = 1'b1;
        if (startDuringWait && edges == 1) begin
          start    = 1'b1;
          src_addr = src + 9'h040;
          dst_addr = dst ^ 27'h0ABCDE;
          length   = len + 10'd3;
        end else
          start = 1'b0;
        prevStall = (ram_wr_valid === 1'b1) && !ram_wr_ready;
        heldAddr  = ram_wr_addr;
        heldData  = ram_wr_data;
        stepCycle();
        edges++;
      end
    end
    checkOutput("done_seen", seenDone, 1);
    start        = 1'b0;
    ram_wr_ready = 1'b1;
    stepCycle();
    checkOutput("busy_after_done", busy, 0);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("valid_after_done", ram_wr_valid, 0);
  endtask

  initial begin
    int          doneCycle;
    int          quiet;
    bit          found;
    logic [8:0]  rs;
    logic [26:0] rd;
    logic [9:0]  rl;

    for (int i = 0; i < 512; i++) rom_mem[i] = 32'hA500_0000 + 32'(i);

    vecs[0] = '{9'h010, 27'h0001000, 10'd4,   -1, 0, 4,   12};
    vecs[1] = '{9'h010, 27'h0001000, 10'd4,    1, 5, 4,   17};
    vecs[2] = '{9'h1FE, 27'h0000200, 10'd4,   -1, 0, 4,   12};
    vecs[3] = '{9'h005, 27'h0000007, 10'd0,   -1, 0, 0,    0};
    vecs[4] = '{9'h000, 27'h7FFFF00, 10'd512, -1, 0, 512, 1536};
    vecs[5] = '{9'h1FF, 27'h7FFFFFF, 10'd3,   -1, 0, 3,    9};
    vecs[6] = '{9'h100, 27'h0000040, 10'd2,    0, 3, 2,    9};

    reset        = 1'b1;
    start        = 1'b0;
    src_addr     = '0;
    dst_addr     = '0;
    length       = '0;
    ram_wr_ready = 1'b0;
    repeat (3) stepCycle();
    reset = 1'b0;
    checkOutput("reset_rom_addr", rom_addr, 0);
    checkOutput("reset_valid", ram_wr_valid, 0);
    checkOutput("reset_wr_addr", ram_wr_addr, 0);
    checkOutput("reset_wr_data", ram_wr_data, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);

    $display("[TB] table-driven block copies");
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].stallWord,
                    vecs[v].stallCycles, 1'b0, 1'b0, doneCycle);
      checkOutput("vec_done_cycle", doneCycle, vecs[v].expDoneCycle);
      checkOutput("vec_writes", obsAddr.size(), vecs[v].expWrites);
      checkBlock("vec", vecs[v].src, vecs[v].dst, vecs[v].len);
    end

    $display("[TB] start ignored while busy");
    applyStimulus(9'h010, 27'h0001000, 10'd4, -1, 0, 1'b0, 1'b1, doneCycle);
    checkOutput("busy_start_done_cycle", doneCycle, 12);
    checkBlock("busy_start", 9'h010, 27'h0001000, 10'd4);

    $display("[TB] reset in the middle of a block");
    obsAddr.delete();
    obsData.delete();
    src_addr     = 9'h020;
    dst_addr     = 27'h0000300;
    length       = 10'd8;
    ram_wr_ready = 1'b1;
    start        = 1'b1;
    stepCycle();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ram_wr_valid === 1'b1 && obsAddr.size() == 2) begin
        found = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput("reset_reach_word2", found, 1);
    ram_wr_ready = 1'b0;
    reset        = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("midreset_valid", ram_wr_valid, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_wr_addr", ram_wr_addr, 0);
    checkOutput("midreset_rom_addr", rom_addr, 0);
    quiet = 0;
    ram_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0 || ram_wr_valid !== 1'b0 || busy !== 1'b0) quiet++;
      stepCycle();
    end
    checkOutput("midreset_quiet", quiet, 0);
    checkOutput("midreset_partial_writes", obsAddr.size(), 2);
    applyStimulus(9'h020, 27'h0000300, 10'd8, -1, 0, 1'b0, 1'b0, doneCycle);
    checkOutput("after_reset_done_cycle", doneCycle, 24);
    checkBlock("after_reset", 9'h020, 27'h0000300, 10'd8);

    $display("[TB] start coinciding with reset");
    reset  = 1'b1;
    start  = 1'b1;
    length = 10'd5;
    stepCycle();
    reset = 1'b0;
    start = 1'b0;
    checkOutput("start_reset_busy", busy, 0);
    stepCycle();
    checkOutput("start_reset_busy_later", busy, 0);

    $display("[TB] randomized copies with random backpressure");
    for (int i = 0; i < 512; i++) rom_mem[i] = $urandom;
    for (int r = 0; r < 6; r++) begin
      rs = 9'($urandom);
      rd = 27'($urandom);
      rl = 10'($urandom_range(0, 24));
      applyStimulus(rs, rd, rl, -1, 0, 1'b1, 1'b0, doneCycle);
      checkOutput("rand_done_min", (doneCycle >= 3 * int'(rl)), 1);
      checkBlock("rand", rs, rd, rl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_copy_engine.md
# rom_copy_engine

Sequential reader for one port of the internal dual-port 512×32 ROM. On a start pulse it streams a block of words from ROM and writes each to a destination memory through a valid/ready write interface. It is used at boot to copy the ROM-resident loader/data image into RAM without CPU involvement. It drives either ROM port (normally the data port) and accounts for the ROM's one-cycle registered read latency.

## Interface
Parameters:
- ROM_ADDR_BITS, 9, ROM word address width (512 words)
- RAM_ADDR_BITS, 27, destination word address width
- DATA_WIDTH, 32, word width

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  ROM_ADDR_BITS  first ROM word address, latched on accepted start
- dst_addr  in  RAM_ADDR_BITS  first destination word address, latched on accepted start
- length  in  ROM_ADDR_BITS+1  word count, 0..512, latched on accepted start
- rom_addr  out  ROM_ADDR_BITS  address to ROM port
- rom_q  in  DATA_WIDTH  ROM port data, valid one cycle after rom_addr is presented
- ram_wr_valid  out  1  write request valid
- ram_wr_ready  in  1  destination accepts write
- ram_wr_addr  out  RAM_ADDR_BITS  write address
- ram_wr_data  out  DATA_WIDTH  write data
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at block completion

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: on start, latch src/dst/length into src_ptr, dst_ptr, remaining. remaining = 0 → DONE; else → READ. start outside IDLE ignored.
- READ: rom_addr = src_ptr (ROM samples it this edge) → WAIT.
- WAIT: rom_q valid; register into ram_wr_data, ram_wr_addr = dst_ptr → WRITE.
- WRITE: ram_wr_valid = 1; addr/data held stable until ram_wr_ready. On valid&&ready edge: src_ptr+1 (wraps mod 2^ROM_ADDR_BITS, 511→0), dst_ptr+1 (wraps mod 2^RAM_ADDR_BITS), remaining−1; if remaining was 1 → DONE, else → READ.
- DONE: done = 1 for exactly this cycle → IDLE.
- rom_addr driven from src_ptr in all states (stable, harmless reads when idle).
- ram_wr_valid never deasserts before handshake except on reset.
- Each source word written exactly once, in ascending (wrapping) address order.

## Timing
- Reset values: state IDLE, rom_addr 0, ram_wr_valid 0, ram_wr_addr 0, ram_wr_data 0, busy 0, done 0; pointers/remaining 0.
- Reset mid-operation: next edge returns to IDLE, ram_wr_valid 0 immediately after that edge; partial block is abandoned, no done pulse.
- start accepted at edge E0; with ram_wr_ready held high, word k transfers at edge E(3k+3); done high in the cycle after E(3N); busy low after E(3N+1). Throughput 3 cycles/word max.
- length = 0: DONE in cycle after E0, done pulse, IDLE after E1; no write issued.
- ram_wr_ready stalls add cycles only in WRITE; nothing else changes.
- start coinciding with reset: reset wins.

## Test plan
- Basic copy: ROM[i]=0xA5000000+i, start src=0x010, dst=0x1000, length=4, ready=1 → writes (0x1000,0xA5000010)…(0x1003,0xA5000013) at E3,E6,E9,E12; done pulse cycle after E12; busy low after E13.
- Backpressure: same block, ready low for 5 cycles on word 1 → ram_wr_valid/addr/data stable throughout stall; only 4 transfers total; done delayed by 5 cycles.
- Source wrap: src=0x1FE, length=4 → reads ROM 0x1FE,0x1FF,0x000,0x001; dst increments linearly.
- Zero length and full ROM: length=0 → done one cycle after start, no ram_wr_valid; length=512, src=0 → 512 writes matching ROM, done after E1536.
- Reset mid-block: reset asserted during WRITE of word 2 of 8 → ram_wr_valid 0, busy 0 after reset edge, no done; new start then copies full block correctly.
- Start while busy: second start pulse during WAIT with different src/length → ignored; original block completes unchanged.
